sdp_ram_be_pipe: RTL and testbench

Parametrised successor to the plain simple dual-port RAM.
- One write port with byte enables and one read port with read-enable.
- Configurable read latency of 1 to 3 cycles, with a valid flag that travels alongside the data.
- Write-first forwarding at byte granularity for same-cycle address collisions.
- Used as the buffer/scratch RAM behind FIFOs and reorder queues where partial-word updates and timing slack are needed.

---
 rtl/sdp_ram_be_pipe_pkg.sv | 27 ++
 rtl/sdp_ram_bank.sv | 50 +++++
 rtl/sdp_ram_be_pipe.sv | 197 +++++++++++++++++++
 tb/tb_sdp_ram_be_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_be_pipe_pkg.sv
// sdp_ram_be_pipe_pkg
//   Shared definitions for the byte-enable simple dual-port RAM family:
//   - log2(): number of address bits needed to represent a value
//     (LOG2_DEPTH = log2(DEPTH-1)); never returns less than 1.
//   - RL_MIN / RL_MAX: legal bounds of the READ_LATENCY parameter.
//   - clr_state_e: state encoding of the optional power-on clear FSM
//     (only used when SDP_RAM_CLEAR_EN is defined).
package sdp_ram_be_pipe_pkg;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if (v >= (1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// sdp_ram_bank
//   Plain storage array with a byte-enable write port and a registered,
//   enable-gated read port. No reset anywhere so it maps onto block RAM.
//   A read of the address being written on the same edge returns the
//   pre-write contents; the caller applies write-first merging.
// Ports:
//   clk    sole clock
//   we     write strobe
//   be     per-lane write enable
//   waddr  write address (writes at or above DEPTH are dropped)
//   wdata  write data
//   re     read enable; rdata holds while re is low
//   raddr  read address
//   rdata  registered read data
module sdp_ram_bank #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int AW         = 9,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = WIDTH / BYTE_WIDTH
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NUM_BYTES-1:0] be,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Out-of-range writes are dropped so a wrapped address can never
  // alias onto a real word.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdp_ram_be_pipe.sv
// sdp_ram_be_pipe
//   Simple dual-port RAM with byte-enable writes, write-first byte-merged
//   forwarding on same-cycle address collisions, and a read pipeline of
//   READ_LATENCY (1..3) cycles with a valid flag travelling with the data.
//   Optional power-on clear FSM, enabled by defining SDP_RAM_CLEAR_EN.
// Ports:
//   clk        sole clock, posedge
//   rst        asynchronous active-high reset (pipeline only, not memory)
//   wr, wr_be  write strobe and per-lane enables
//   addr_a, d  write address / data
//   rd_en      read request
//   addr_b     read address
//   q, q_valid read data and its valid flag
//   init_busy  (SDP_RAM_CLEAR_EN only) high while the array is being zeroed
// Handshake: there is no backpressure. Every cycle with rd_en high is one
//   accepted read; exactly READ_LATENCY edges later q_valid is high for one
//   cycle with its data on q. When q_valid is low, q holds its last value.
module sdp_ram_be_pipe
  import sdp_ram_be_pipe_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 512,
  parameter int LOG2_DEPTH   = log2(DEPTH - 1),
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_BYTES    = WIDTH / BYTE_WIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [LOG2_DEPTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      d,
  input  logic                  rd_en,
  input  logic [LOG2_DEPTH-1:0] addr_b,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
`ifdef SDP_RAM_CLEAR_EN
  ,output logic                 init_busy
`endif
);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
    $error("sdp_ram_be_pipe: READ_LATENCY must be 1, 2 or 3");
  end
  if (WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sdp_ram_be_pipe: WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                  rd_eff, wr_eff;
  logic                  bank_we;
  logic [NUM_BYTES-1:0]  bank_be;
  logic [LOG2_DEPTH-1:0] bank_waddr;
  logic [WIDTH-1:0]      bank_wdata;
  logic [WIDTH-1:0]      ram_q;

`ifdef SDP_RAM_CLEAR_EN
  // Clear FSM: sweeps zero words over 0..DEPTH-1, one per cycle, while
  // user reads and writes are blocked.
  localparam logic [LOG2_DEPTH-1:0] LAST_ADDR = LOG2_DEPTH'(DEPTH - 1);

  clr_state_e            clr_state_q, clr_state_d;
  logic [LOG2_DEPTH-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state_q <= CLEAR;
      clr_cnt_q   <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    if (clr_state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        clr_state_d = RUN;
        clr_cnt_d   = '0;
      end
    end
  end

  assign init_busy  = (clr_state_q == CLEAR);
  assign rd_eff     = rd_en & ~init_busy;
  assign wr_eff     = wr & ~init_busy;
  assign bank_we    = init_busy | wr;
  assign bank_be    = init_busy ? '1 : wr_be;
  assign bank_waddr = init_busy ? clr_cnt_q : addr_a;
  assign bank_wdata = init_busy ? '0 : d;
`else
  assign rd_eff     = rd_en;
  assign wr_eff     = wr;
  assign bank_we    = wr;
  assign bank_be    = wr_be;
  assign bank_waddr = addr_a;
  assign bank_wdata = d;
`endif

  sdp_ram_bank #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .AW         (LOG2_DEPTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .NUM_BYTES  (NUM_BYTES)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (bank_be),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (rd_eff),
    .raddr (addr_b),
    .rdata (ram_q)
  );

  // Stage 1 side registers: the collision flag and the write data/lanes
  // seen on the read edge. They load only with a read so the merged word
  // holds along with the bank output between reads.
  logic                 v1;
  logic                 hit_r;
  logic [WIDTH-1:0]     d_r;
  logic [NUM_BYTES-1:0] be_r;
  logic [WIDTH-1:0]     merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      hit_r <= 1'b0;
      d_r   <= '0;
      be_r  <= '0;
    end else begin
      v1 <= rd_eff;
      if (rd_eff) begin
        hit_r <= wr_eff && (addr_a == addr_b);
        d_r   <= d;
        be_r  <= wr_be;
      end
    end
  end

  // Write-first merge: lanes written on the read edge come from the
  // registered write data, the rest from the pre-write RAM word.
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (hit_r && be_r[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = d_r[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // The RAM register has no reset, so q is masked to zero until the
    // first read after reset has landed.
    logic seen_r;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         seen_r <= 1'b0;
      else if (rd_eff) seen_r <= 1'b1;
    end
    assign q       = seen_r ? merged : '0;
    assign q_valid = v1;
  end else begin : g_latn
    logic             s2_v;
    logic [WIDTH-1:0] s2_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_v <= 1'b0;
        s2_q <= '0;
      end else begin
        s2_v <= v1;
        if (v1) s2_q <= merged;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      assign q       = s2_q;
      assign q_valid = s2_v;
    end else begin : g_lat3
      logic             s3_v;
      logic [WIDTH-1:0] s3_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s3_v <= 1'b0;
          s3_q <= '0;
        end else begin
          s3_v <= s2_v;
          if (s2_v) s3_q <= s2_q;
        end
      end
      assign q       = s3_q;
      assign q_valid = s3_v;
    end
  end

endmodule

// File: tb/tb_sdp_ram_be_pipe.sv
// tb_sdp_ram_be_pipe
//   Bench for sdp_ram_be_pipe (WIDTH=64, DEPTH=16, READ_LATENCY=2).
//   The reference model is a word array updated with the write-first rule:
//   a read returns the memory word after the same-edge write is applied.
//   Expected read results are queued with the edge number on which they are
//   due; a scoreboard compares every cycle. Defining SDP_RAM_CLEAR_EN adds
//   the clear-sequence test.
module tb_sdp_ram_be_pipe;

  localparam int W   = 64;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int NB  = 8;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic [NB-1:0] wr_be = '0;
  logic [AW-1:0] addr_a = '0;
  logic [W-1:0]  d = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [W-1:0]  q;
  logic          q_valid;
`ifdef SDP_RAM_CLEAR_EN
  logic          init_busy;
`endif

  always #5 clk = ~clk;

  sdp_ram_be_pipe #(
    .WIDTH        (W),
    .DEPTH        (DEP),
    .BYTE_WIDTH   (8),
    .READ_LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wr_be   (wr_be),
    .addr_a  (addr_a),
    .d       (d),
    .rd_en   (rd_en),
    .addr_b  (addr_b),
    .q       (q),
    .q_valid (q_valid)
`ifdef SDP_RAM_CLEAR_EN
    ,.init_busy (init_busy)
`endif
  );

  // ---------------- model and scoreboard state ----------------
  int              total = 0;
  int              bad = 0;
  int unsigned     edge_n = 0;
  int              clr_left = 0;
  bit              chk_en = 1'b0;
  logic [W-1:0]    mem_m [DEP];
  logic [W-1:0]    exp_q [$];
  int unsigned     due_q [$];
  logic [W-1:0]    last_q = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [W-1:0] apply_be(input logic [W-1:0] old,
                                            input logic [W-1:0] nw,
                                            input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives one cycle, updates the model at the edge,
  // and returns at the following negedge.
  task automatic drive(input logic w, input logic [NB-1:0] be, input logic [AW-1:0] aa,
                       input logic [W-1:0] dd, input logic re, input logic [AW-1:0] ab);
    int unsigned t;
    wr = w; wr_be = be; addr_a = aa; d = dd; rd_en = re; addr_b = ab;
    @(posedge clk);
    t = edge_n;
    if (clr_left != 0) begin
      clr_left--;
    end else begin
      if (w) mem_m[aa] = apply_be(mem_m[aa], dd, be);
      if (re) begin
        exp_q.push_back(mem_m[ab]);
        due_q.push_back(t + LAT);
      end
    end
    @(negedge clk);
    wr = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input bit wait_clear);
    chk_en = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_q = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef SDP_RAM_CLEAR_EN
    clr_left = DEP;
    for (int i = 0; i < DEP; i++) mem_m[i] = '0;
`endif
    chk_en = 1'b1;
    if (wait_clear) while (clr_left != 0) idle();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        if (q_valid !== 1'b1 || q !== exp_q[0]) begin
          bad++;
          $display("FAIL sb_read edge=%0d: got valid=%b q=%h, want valid=1 q=%h",
                   edge_n, q_valid, q, exp_q[0]);
        end
        last_q = exp_q[0];
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        if (q_valid !== 1'b0 || q !== last_q) begin
          bad++;
          $display("FAIL sb_idle edge=%0d: got valid=%b q=%h, want valid=0 q=%h",
                   edge_n, q_valid, q, last_q);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if (q_valid !== 1'b0 || q !== '0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b q=%h, want valid=0 q=0", q_valid, q);
    end
`ifdef SDP_RAM_CLEAR_EN
    total++;
    if (init_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy: got %b want 1", init_busy);
    end
`endif
    do_reset(1'b1);
  endtask

  task automatic test_full_word();
    drive(1'b1, 8'hFF, 4'd5, 64'h0123456789ABCDEF, 1'b0, '0);
    idle();
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5);
    total++;
    if (q_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_early: got valid=%b want 0", q_valid);
    end
    idle();
    total++;
    if (q_valid !== 1'b1 || q !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL full_word: got valid=%b q=%h want valid=1 q=0123456789abcdef", q_valid, q);
    end
    idle();
    total++;
    if (q_valid !== 1'b0 || q !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL full_hold: got valid=%b q=%h want valid=0 q=0123456789abcdef", q_valid, q);
    end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 8'hFF, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
    drive(1'b1, 8'h0F, 4'd7, 64'h0, 1'b0, '0);
    drive(1'b1, 8'h00, 4'd7, 64'h0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd7);
    idle();
    total++;
    if (q_valid !== 1'b1 || q !== 64'hFFFFFFFF00000000) begin
      bad++;
      $display("FAIL byte_en: got valid=%b q=%h want valid=1 q=ffffffff00000000", q_valid, q);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 8'hFF, 4'd3, {8{8'hAA}}, 1'b0, '0);
    drive(1'b1, 8'hF0, 4'd3, {8{8'h55}}, 1'b1, 4'd3);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3);
    total++;
    if (q_valid !== 1'b1 || q !== 64'h55555555AAAAAAAA) begin
      bad++;
      $display("FAIL collide_fwd: got valid=%b q=%h want valid=1 q=55555555aaaaaaaa", q_valid, q);
    end
    // A same-address write right behind the read must not leak into it.
    drive(1'b1, 8'hFF, 4'd3, 64'h0, 1'b0, '0);
    total++;
    if (q_valid !== 1'b1 || q !== 64'h55555555AAAAAAAA) begin
      bad++;
      $display("FAIL collide_next: got valid=%b q=%h want valid=1 q=55555555aaaaaaaa", q_valid, q);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = {$urandom, $urandom};
      drive(1'b1, 8'hFF, AW'(i), v[i], 1'b0, '0);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
      if (i > 0) begin
        total++;
        if (q_valid !== 1'b1 || q !== v[i-1]) begin
          bad++;
          $display("FAIL b2b_%0d: got valid=%b q=%h want valid=1 q=%h", i-1, q_valid, q, v[i-1]);
        end
      end
    end
    idle();
    total++;
    if (q_valid !== 1'b1 || q !== v[3]) begin
      bad++;
      $display("FAIL b2b_3: got valid=%b q=%h want valid=1 q=%h", q_valid, q, v[3]);
    end
    idle();
    total++;
    if (q_valid !== 1'b0 || q !== v[3]) begin
      bad++;
      $display("FAIL b2b_hold: got valid=%b q=%h want valid=0 q=%h", q_valid, q, v[3]);
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] want;
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (q_valid !== 1'b0 || q !== '0) begin
      bad++;
      $display("FAIL midflight_rst: got valid=%b q=%h want valid=0 q=0", q_valid, q);
    end
    @(negedge clk);
    do_reset(1'b1);
    want = mem_m[5];
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5);
    idle();
    total++;
    if (q_valid !== 1'b1 || q !== want) begin
      bad++;
      $display("FAIL midflight_keep: got valid=%b q=%h want valid=1 q=%h", q_valid, q, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < DEP; i++) drive(1'b1, 8'hFF, AW'(i), {$urandom, $urandom}, 1'b0, '0);
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), NB'($urandom_range(0, 255)), AW'($urandom_range(0, DEP-1)),
            {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, DEP-1)));
    end
    for (int n = 0; n < LAT + 2; n++) idle();
    total++;
    if (due_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: got %0d reads outstanding, want 0", due_q.size());
    end
  endtask

`ifdef SDP_RAM_CLEAR_EN
  task automatic test_clear();
    do_reset(1'b0);
    for (int i = 0; i < DEP; i++) begin
      total++;
      if (init_busy !== 1'b1) begin
        bad++;
        $display("FAIL clear_busy_%0d: got %b want 1", i, init_busy);
      end
      drive(1'b1, 8'hFF, AW'(i), {$urandom, $urandom}, 1'b1, AW'($urandom_range(0, DEP-1)));
    end
    total++;
    if (init_busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_done: got %b want 0", init_busy);
    end
    for (int i = 0; i < DEP; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
    for (int n = 0; n < LAT + 1; n++) idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_full_word();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef SDP_RAM_CLEAR_EN
    test_clear();
`endif
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
